// File: rtl/demux2_stream_pkg.sv
// rtl/demux2_stream_pkg.sv - shared defaults, select encodings and slot state for demux2_stream
package demux2_stream_pkg;

    localparam int DEF_DWIDTH = 8;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux2_slot.sv
// rtl/demux2_slot.sv - one-entry output register slot; DEMUX2_CNT_EN adds a drain counter
module demux2_slot
    import demux2_stream_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
`ifdef DEMUX2_CNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data
`ifdef DEMUX2_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_cnt
`endif
);

    slot_state_t       r_state;
    logic [DWIDTH-1:0] r_data;

    // A load into a FULL slot only happens when the consumer drains in the
    // same cycle, so the slot simply takes the new beat and stays FULL.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (i_load) begin
                        r_data  <= i_data;
                        r_state <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (i_load) begin
                        r_data <= i_data;
                    end else if (i_ready) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

`ifdef DEMUX2_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if ((r_state == SLOT_FULL) && i_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1-to-2 stream demultiplexer; DEMUX2_CNT_EN adds per-output drain counters
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
`ifdef DEMUX2_CNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sel,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_valid0,
    input  logic              i_ready0,
    output logic [DWIDTH-1:0] o_data0,
    output logic              o_valid1,
    input  logic              i_ready1,
    output logic [DWIDTH-1:0] o_data1
`ifdef DEMUX2_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_cnt0,
    output logic [CNT_WIDTH-1:0] o_cnt1
`endif
);

    logic w_room0;
    logic w_room1;
    logic w_load0;
    logic w_load1;

    assign w_room0 = !o_valid0 || i_ready0;
    assign w_room1 = !o_valid1 || i_ready1;
    assign o_ready = (i_sel == SEL_OUT1) ? w_room1 : w_room0;

    // Loads are qualified by i_valid so a don't-care i_sel never reaches a slot.
    assign w_load0 = i_valid && w_room0 && (i_sel == SEL_OUT0);
    assign w_load1 = i_valid && w_room1 && (i_sel == SEL_OUT1);

    demux2_slot #(
        .DWIDTH   (DWIDTH)
`ifdef DEMUX2_CNT_EN
        ,
        .CNT_WIDTH(CNT_WIDTH)
`endif
    ) u_slot0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load0),
        .i_data (i_data),
        .i_ready(i_ready0),
        .o_valid(o_valid0),
        .o_data (o_data0)
`ifdef DEMUX2_CNT_EN
        ,
        .o_cnt  (o_cnt0)
`endif
    );

    demux2_slot #(
        .DWIDTH   (DWIDTH)
`ifdef DEMUX2_CNT_EN
        ,
        .CNT_WIDTH(CNT_WIDTH)
`endif
    ) u_slot1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load1),
        .i_data (i_data),
        .i_ready(i_ready1),
        .o_valid(o_valid1),
        .o_data (o_data1)
`ifdef DEMUX2_CNT_EN
        ,
        .o_cnt  (o_cnt1)
`endif
    );

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - self-checking bench for demux2_stream (DEMUX2_CNT_EN enables counter checks)
module tb_demux2_stream;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic       i_sel;
    logic [7:0] i_data;
    logic       o_valid0;
    logic       i_ready0;
    logic [7:0] o_data0;
    logic       o_valid1;
    logic       i_ready1;
    logic [7:0] o_data1;
`ifdef DEMUX2_CNT_EN
    logic [3:0] o_cnt0;
    logic [3:0] o_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux2_stream #(
        .DWIDTH   (8)
`ifdef DEMUX2_CNT_EN
        ,
        .CNT_WIDTH(4)
`endif
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sel   (i_sel),
        .i_data  (i_data),
        .o_valid0(o_valid0),
        .i_ready0(i_ready0),
        .o_data0 (o_data0),
        .o_valid1(o_valid1),
        .i_ready1(i_ready1),
        .o_data1 (o_data1)
`ifdef DEMUX2_CNT_EN
        ,
        .o_cnt0  (o_cnt0),
        .o_cnt1  (o_cnt1)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic do_reset();
        @(negedge i_clk);
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_sel    = 1'b0;
        i_data   = 8'h00;
        i_ready0 = 1'b0;
        i_ready1 = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got v0=%b v1=%b expected 0 0", o_valid0, o_valid1);
        end
        n_checks++;
        if (o_data0 !== 8'h00 || o_data1 !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_data: got d0=%h d1=%h expected 00 00", o_data0, o_data1);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 1", o_ready);
        end
`ifdef DEMUX2_CNT_EN
        n_checks++;
        if (o_cnt0 !== 4'd0 || o_cnt1 !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got c0=%0d c1=%0d expected 0 0", o_cnt0, o_cnt1);
        end
`endif
    endtask

    task automatic test_single_beat();
        do_reset();
        i_ready1 = 1'b1;
        i_sel    = 1'b1;
        i_data   = 8'hA5;
        i_valid  = 1'b1;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ready: got %b expected 1", o_ready);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 8'h00;
        #1;
        n_checks++;
        if (o_valid1 !== 1'b1 || o_data1 !== 8'hA5 || o_valid0 !== 1'b0) begin
            n_errors++;
            $display("FAIL single_out: got v1=%b d1=%h v0=%b expected 1 a5 0", o_valid1, o_data1, o_valid0);
        end
        @(negedge i_clk);
        #1;
        n_checks++;
        if (o_valid1 !== 1'b0 || o_valid0 !== 1'b0) begin
            n_errors++;
            $display("FAIL single_once: got v1=%b v0=%b expected 0 0", o_valid1, o_valid0);
        end
    endtask

    task automatic test_stall_isolation();
        do_reset();
        i_ready0 = 1'b0;
        i_ready1 = 1'b1;
        i_sel    = 1'b0;
        i_data   = 8'h11;
        i_valid  = 1'b1;
        @(negedge i_clk);
        i_sel  = 1'b1;
        i_data = 8'h22;
        #1;
        n_checks++;
        if (o_valid0 !== 1'b1 || o_data0 !== 8'h11 || o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_sel1: got v0=%b d0=%h rdy=%b expected 1 11 1", o_valid0, o_data0, o_ready);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_sel   = 1'b0;
        #1;
        n_checks++;
        if (o_valid1 !== 1'b1 || o_data1 !== 8'h22 || o_valid0 !== 1'b1 || o_data0 !== 8'h11) begin
            n_errors++;
            $display("FAIL stall_out1: got v1=%b d1=%h v0=%b d0=%h expected 1 22 1 11",
                     o_valid1, o_data1, o_valid0, o_data0);
        end
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_sel0_blocked: got rdy=%b expected 0", o_ready);
        end
        i_ready0 = 1'b1;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: got rdy=%b expected 1", o_ready);
        end
        @(negedge i_clk);
        #1;
        n_checks++;
        if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_drained: got v0=%b v1=%b expected 0 0", o_valid0, o_valid1);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        do_reset();
        i_ready0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_sel   = 1'b0;
            i_data  = 8'(i);
            i_valid = 1'b1;
            #1;
            if (o_ready !== 1'b1) bad++;
            if (i > 0 && (o_valid0 !== 1'b1 || o_data0 !== 8'(i - 1))) bad++;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        #1;
        if (o_valid0 !== 1'b1 || o_data0 !== 8'h0F) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL b2b_stream: got %0d bad cycles expected 0", bad);
        end
        @(negedge i_clk);
        #1;
        n_checks++;
        if (o_valid0 !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_tail: got v0=%b expected 0", o_valid0);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        bad = 0;
        do_reset();
        i_ready0 = 1'b0;
        i_ready1 = 1'b0;
        i_sel    = 1'b0;
        i_data   = 8'h33;
        i_valid  = 1'b1;
        @(negedge i_clk);
        i_sel  = 1'b1;
        i_data = 8'h44;
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        n_checks++;
        if (o_valid0 !== 1'b1 || o_data0 !== 8'h33 || o_valid1 !== 1'b1 || o_data1 !== 8'h44) begin
            n_errors++;
            $display("FAIL midrst_full: got v0=%b d0=%h v1=%b d1=%h expected 1 33 1 44",
                     o_valid0, o_data0, o_valid1, o_data1);
        end
        #1;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0 || o_data0 !== 8'h00 || o_data1 !== 8'h00) begin
            n_errors++;
            $display("FAIL midrst_async: got v0=%b v1=%b d0=%h d1=%h expected 0 0 00 00",
                     o_valid0, o_valid1, o_data0, o_data1);
        end
        @(negedge i_clk);
        i_rst    = 1'b0;
        i_ready0 = 1'b1;
        i_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            #1;
            if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL midrst_ghost: got %0d cycles with a beat expected 0", bad);
        end
    endtask

`ifdef DEMUX2_CNT_EN
    task automatic test_counter_wrap();
        do_reset();
        i_ready1 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            i_sel   = 1'b1;
            i_data  = 8'(8'h80 + i);
            i_valid = 1'b1;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        n_checks++;
        if (o_cnt1 !== 4'd1 || o_cnt0 !== 4'd0) begin
            n_errors++;
            $display("FAIL cnt_wrap: got c0=%0d c1=%0d expected 0 1", o_cnt0, o_cnt1);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic       exp_ready;
        logic       hold;
        int         drains0;
        int         drains1;
        int         bad_valid;
        int         bad_ready;
        int         bad_data;
        int         bad_hold;
        logic       prev_sel;
        logic [7:0] prev_data;
        drains0   = 0;
        drains1   = 0;
        bad_valid = 0;
        bad_ready = 0;
        bad_data  = 0;
        bad_hold  = 0;
        hold      = 1'b0;
        prev_sel  = 1'b0;
        prev_data = 8'h00;
        do_reset();
        for (int cyc = 0; cyc < 110; cyc++) begin
            if (hold) begin
                i_valid = 1'b1;
            end else if (cyc < 100) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_sel   = 1'($urandom_range(0, 1));
                i_data  = 8'($urandom_range(0, 255));
            end else begin
                i_valid = 1'b0;
            end
            if (hold && (i_sel !== prev_sel || i_data !== prev_data)) bad_hold++;
            i_ready0 = (cyc >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            i_ready1 = (cyc >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (o_valid0 !== (q0.size() > 0) || o_valid1 !== (q1.size() > 0)) bad_valid++;
            exp_ready = i_sel ? (q1.size() == 0 || i_ready1) : (q0.size() == 0 || i_ready0);
            if (o_ready !== exp_ready) bad_ready++;
            if (q0.size() > 0 && i_ready0) begin
                if (o_data0 !== q0[0]) bad_data++;
                void'(q0.pop_front());
                drains0++;
            end
            if (q1.size() > 0 && i_ready1) begin
                if (o_data1 !== q1[0]) bad_data++;
                void'(q1.pop_front());
                drains1++;
            end
            if (i_valid && exp_ready) begin
                if (i_sel) q1.push_back(i_data);
                else       q0.push_back(i_data);
            end
            hold      = i_valid && !exp_ready;
            prev_sel  = i_sel;
            prev_data = i_data;
            @(negedge i_clk);
        end
        n_checks++;
        if (bad_valid != 0) begin
            n_errors++;
            $display("FAIL rand_valid: got %0d mismatching cycles expected 0", bad_valid);
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_errors++;
            $display("FAIL rand_ready: got %0d mismatching cycles expected 0", bad_ready);
        end
        n_checks++;
        if (bad_data != 0) begin
            n_errors++;
            $display("FAIL rand_order: got %0d wrong beats expected 0", bad_data);
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_errors++;
            $display("FAIL rand_upstream_hold: got %0d violations expected 0", bad_hold);
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0 || o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_loss: got pending q0=%0d q1=%0d v0=%b v1=%b expected 0 0 0 0",
                     q0.size(), q1.size(), o_valid0, o_valid1);
        end
`ifdef DEMUX2_CNT_EN
        n_checks++;
        if (o_cnt0 !== 4'(drains0 % 16) || o_cnt1 !== 4'(drains1 % 16)) begin
            n_errors++;
            $display("FAIL rand_cnt: got c0=%0d c1=%0d expected %0d %0d",
                     o_cnt0, o_cnt1, drains0 % 16, drains1 % 16);
        end
`else
        n_checks++;
        if (drains0 + drains1 == 0) begin
            n_errors++;
            $display("FAIL rand_activity: got 0 drained beats expected more than 0");
        end
`endif
    endtask

    initial begin
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_sel    = 1'b0;
        i_data   = 8'h00;
        i_ready0 = 1'b0;
        i_ready1 = 1'b0;
        test_reset();
        test_single_beat();
        test_stall_isolation();
        test_back_to_back();
        test_mid_reset();
`ifdef DEMUX2_CNT_EN
        test_counter_wrap();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
